icache: RTL



---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_if.sv | 29 ++
 rtl/icache_store.sv | 46 ++++
 rtl/icache.sv | 112 +++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ICACHE_INDEX_BITS = 7;
  localparam int ICACHE_ADDR_WIDTH = 32;
  localparam int ICACHE_DATA_WIDTH = 32;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// inst_valid and if_done are single-cycle pulses that qualify their data buses.
// fetch_req is level-held with fetch_pc stable until inst_valid is seen.
// if_req is level-held with if_addr stable until completion or flush.
interface icache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  flush;
  logic                  inst_valid;
  logic [31:0]           inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [31:0]           if_data;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_done;

  modport slave (
    input  fetch_req, fetch_pc, flush, if_data, if_pc, if_done,
    output inst_valid, inst, inst_pc, if_req, if_addr
  );

  modport master (
    output fetch_req, fetch_pc, flush, if_data, if_pc, if_done,
    input  inst_valid, inst, inst_pc, if_req, if_addr
  );
endinterface

// File: rtl/icache_store.sv
// Valid/tag/data arrays: combinational lookup port and one synchronous write port.
module icache_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = ICACHE_ADDR_WIDTH - ICACHE_INDEX_BITS - 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INDEX_BITS-1:0]        rindex,
  input  logic [TAG_BITS-1:0]          rtag,
  output logic                         hit,
  output logic [ICACHE_DATA_WIDTH-1:0] rword,
  input  logic                         we,
  input  logic [INDEX_BITS-1:0]        windex,
  input  logic [TAG_BITS-1:0]          wtag,
  input  logic [ICACHE_DATA_WIDTH-1:0] wdata
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]             valid;
  logic [TAG_BITS-1:0]          tag_mem  [LINES];
  logic [ICACHE_DATA_WIDTH-1:0] data_mem [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[windex] <= TRUE;
    end
  end

  // Tag and data carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[windex]  <= wtag;
      data_mem[windex] <= wdata;
    end
  end

  // A same-cycle write is not forwarded: the lookup sees the old line.
  assign hit   = valid[rindex] && (tag_mem[rindex] == rtag);
  assign rword = data_mem[rindex];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: hit/miss FSM and handshake registers around icache_store.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  icache_if.slave bus,
  output state_t dbg_state
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  state_t                       state;
  logic [ADDR_WIDTH-1:0]        miss_addr;
  logic                         inst_valid_r;
  logic [ICACHE_DATA_WIDTH-1:0] inst_r;
  logic [ADDR_WIDTH-1:0]        inst_pc_r;
  logic                         if_req_r;
  logic [ADDR_WIDTH-1:0]        if_addr_r;

  logic                         hit;
  logic [ICACHE_DATA_WIDTH-1:0] rword;
  logic [INDEX_BITS-1:0]        lookup_index;
  logic [TAG_BITS-1:0]          lookup_tag;
  logic [INDEX_BITS-1:0]        fill_index;
  logic [TAG_BITS-1:0]          fill_tag;
  logic                         accept;
  logic                         resp_match;

  assign lookup_index = bus.fetch_pc[INDEX_BITS+1:2];
  assign lookup_tag   = bus.fetch_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_index   = bus.if_pc[INDEX_BITS+1:2];
  assign fill_tag     = bus.if_pc[ADDR_WIDTH-1:INDEX_BITS+2];

  // The delivery cycle is never an acceptance cycle, so one request yields one pulse.
  assign accept     = bus.fetch_req && !inst_valid_r && !bus.flush;
  assign resp_match = bus.if_done && (bus.if_pc == miss_addr);

  // Every returned word is kept, including late responses to a flushed miss.
  icache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .rindex (lookup_index),
    .rtag   (lookup_tag),
    .hit    (hit),
    .rword  (rword),
    .we     (bus.if_done),
    .windex (fill_index),
    .wtag   (fill_tag),
    .wdata  (bus.if_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ICACHE_IDLE;
      miss_addr    <= '0;
      inst_valid_r <= FALSE;
      inst_r       <= '0;
      inst_pc_r    <= '0;
      if_req_r     <= FALSE;
      if_addr_r    <= '0;
    end else begin
      inst_valid_r <= FALSE;
      if (bus.flush) begin
        // if_addr is left alone so the next miss address change restarts the controller.
        if_req_r <= FALSE;
        state    <= ICACHE_IDLE;
      end else begin
        case (state)
          ICACHE_IDLE: begin
            if (accept) begin
              if (hit) begin
                inst_valid_r <= TRUE;
                inst_r       <= rword;
                inst_pc_r    <= bus.fetch_pc;
              end else begin
                miss_addr <= bus.fetch_pc;
                if_addr_r <= bus.fetch_pc;
                if_req_r  <= TRUE;
                state     <= ICACHE_MISS;
              end
            end
          end
          ICACHE_MISS: begin
            if (resp_match) begin
              inst_valid_r <= TRUE;
              inst_r       <= bus.if_data;
              inst_pc_r    <= bus.if_pc;
              if_req_r     <= FALSE;
              state        <= ICACHE_IDLE;
            end
          end
          default: state <= ICACHE_IDLE;
        endcase
      end
    end
  end

  assign bus.inst_valid = inst_valid_r;
  assign bus.inst       = inst_r;
  assign bus.inst_pc    = inst_pc_r;
  assign bus.if_req     = if_req_r;
  assign bus.if_addr    = if_addr_r;
  assign dbg_state      = state;

endmodule
